// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse-position conditioning slice.
//   MOUSE_W / SCREEN_XMAX / SCREEN_YMAX : default coordinate width and screen window
//   mouse_pos_t                         : committed position record at the default width
//   settle_state_t                      : settle-filter FSM states
package mouse_pkg;

    localparam int MOUSE_W     = 12;
    localparam int SCREEN_XMAX = 1023;
    localparam int SCREEN_YMAX = 767;

    typedef struct packed {
        logic [MOUSE_W-1:0] x;
        logic [MOUSE_W-1:0] y;
        logic               clamp;
    } mouse_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT
    } settle_state_t;

endpackage

// File: rtl/mouse_pos_conditioner_if.sv
// Bundle between the PS/2 mouse controller side and the position conditioner.
//   xpos_mouse_in / ypos_mouse_in / pos_valid_in : raw strobed samples into the conditioner
//   xpos_mouse / ypos_mouse                      : conditioned position, held between updates
//   pos_valid / moved                            : 1-cycle update and motion pulses
//   clamped                                      : last committed sample was clamped
// master = sample source / position consumer, slave = the conditioner.
interface mouse_pos_conditioner_if #(
    parameter int W = mouse_pkg::MOUSE_W
) ();

    logic [W-1:0] xpos_mouse_in;
    logic [W-1:0] ypos_mouse_in;
    logic         pos_valid_in;
    logic [W-1:0] xpos_mouse;
    logic [W-1:0] ypos_mouse;
    logic         pos_valid;
    logic         moved;
    logic         clamped;

    modport master (
        output xpos_mouse_in, ypos_mouse_in, pos_valid_in,
        input  xpos_mouse, ypos_mouse, pos_valid, moved, clamped
    );

    modport slave (
        input  xpos_mouse_in, ypos_mouse_in, pos_valid_in,
        output xpos_mouse, ypos_mouse, pos_valid, moved, clamped
    );

endinterface

// File: rtl/mouse_pos_pipe.sv
// Valid-tagged delay line, STAGES registers deep, shifting every cycle.
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid, in_data     : entry pushed into stage 1
//   out_valid, out_data   : contents of the last stage
// Reset clears every stage so in-flight entries are discarded.
module mouse_pos_pipe #(
    parameter int STAGES = 2,
    parameter int DW     = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] data_q [STAGES];
    logic          vld_q  [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else begin
            data_q[0] <= in_data;
            vld_q[0]  <= in_valid;
            for (int unsigned i = 1; i < STAGES; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/mouse_pos_conditioner.sv
// Mouse position conditioner (pixel clock domain).
// Clamps strobed x/y samples to the screen window, optionally rejects transient
// positions with a settle filter, delays committed positions through a
// STAGES-deep pipeline and registers them with update/motion/clamp flags.
//   clk  : pixel clock
//   rst  : asynchronous reset, active-low
//   bus  : slave side of mouse_pos_conditioner_if (raw samples in, conditioned
//          position, pos_valid, moved and clamped out)
// Parameters: W coordinate width, XMAX/YMAX clamp limits, STAGES pipeline depth
// (1..4), STABLE_CNT settle cycles before commit (0 bypasses the filter).
module mouse_pos_conditioner
    import mouse_pkg::*;
#(
    parameter int W          = MOUSE_W,
    parameter int XMAX       = SCREEN_XMAX,
    parameter int YMAX       = SCREEN_YMAX,
    parameter int STAGES     = 2,
    parameter int STABLE_CNT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    mouse_pos_conditioner_if.slave  bus
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         clamp;
    } pos_t;

    localparam logic [W-1:0] XLIM = W'(XMAX);
    localparam logic [W-1:0] YLIM = W'(YMAX);

    pos_t smp;
    logic push_valid;
    pos_t push_data;
    logic pipe_valid;
    pos_t pipe_out;

    always_comb begin
        smp.x     = (bus.xpos_mouse_in > XLIM) ? XLIM : bus.xpos_mouse_in;
        smp.y     = (bus.ypos_mouse_in > YLIM) ? YLIM : bus.ypos_mouse_in;
        smp.clamp = (bus.xpos_mouse_in > XLIM) | (bus.ypos_mouse_in > YLIM);
    end

    generate
        if (STABLE_CNT == 0) begin : g_bypass
            assign push_valid = bus.pos_valid_in;
            assign push_data  = smp;
        end else begin : g_filter
            localparam int             CW       = $clog2(STABLE_CNT + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);
            localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CNT);

            settle_state_t state_q, state_d;
            pos_t          cand_q, cand_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [W-1:0]  last_x_q, last_y_q;
            logic          is_new;
            logic          same_cand;
            logic          commit;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q  <= IDLE;
                    cand_q   <= '0;
                    cnt_q    <= '0;
                    last_x_q <= '0;
                    last_y_q <= '0;
                end else begin
                    state_q <= state_d;
                    cand_q  <= cand_d;
                    cnt_q   <= cnt_d;
                    if (commit) begin
                        last_x_q <= cand_q.x;
                        last_y_q <= cand_q.y;
                    end
                end
            end

            always_comb begin
                state_d   = state_q;
                cand_d    = cand_q;
                cnt_d     = cnt_q;
                commit    = 1'b0;
                is_new    = bus.pos_valid_in && ({smp.x, smp.y} != {last_x_q, last_y_q});
                same_cand = ({smp.x, smp.y} == {cand_q.x, cand_q.y});
                unique case (state_q)
                    IDLE: begin
                        if (is_new) begin
                            cand_d  = smp;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (bus.pos_valid_in && !is_new) begin
                            // Returned to the committed position: the excursion was a glitch.
                            cand_d  = '0;
                            state_d = IDLE;
                        end else if (is_new && !same_cand) begin
                            cand_d = smp;
                            cnt_d  = '0;
                        end else begin
                            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) state_d = COMMIT;
                        end
                    end
                    COMMIT: begin
                        commit  = 1'b1;
                        state_d = IDLE;
                        // The candidate becomes the committed value this edge, so newness
                        // is judged against the candidate rather than the stale register.
                        if (bus.pos_valid_in && !same_cand) begin
                            cand_d  = smp;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            assign push_valid = commit;
            assign push_data  = cand_q;
        end
    endgenerate

    mouse_pos_pipe #(
        .STAGES (STAGES),
        .DW     ($bits(pos_t))
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_valid),
        .in_data   (push_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.xpos_mouse <= '0;
            bus.ypos_mouse <= '0;
            bus.pos_valid  <= 1'b0;
            bus.moved      <= 1'b0;
            bus.clamped    <= 1'b0;
        end else begin
            bus.pos_valid <= pipe_valid;
            bus.moved     <= pipe_valid &&
                             ({pipe_out.x, pipe_out.y} != {bus.xpos_mouse, bus.ypos_mouse});
            if (pipe_valid) begin
                bus.xpos_mouse <= pipe_out.x;
                bus.ypos_mouse <= pipe_out.y;
                bus.clamped    <= pipe_out.clamp;
            end
        end
    end

endmodule
